// File: rtl/lcd_pkg.sv
// Shared types and defaults for the LCD text buffer.
// Cells are stored row-major; cell_idx gives the flat index.
package lcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    REQ
  } state_t;

  localparam int LCD_COL_W  = 6;
  localparam int LCD_ROW_W  = 1;
  localparam int LCD_CHAR_W = 8;

  localparam logic [7:0] LCD_BLANK = 8'h20;

  function automatic int cell_idx(
    input int row,
    input int col,
    input int cols
  );
    return row * cols + col;
  endfunction

endpackage

// File: rtl/lcd_char_ram.sv
// Character cell store: flop array, async reset to blank,
// one synchronous write port and one combinational read port.
module lcd_char_ram
  import lcd_pkg::*;
#(
  parameter int ROWS   = 2,
  parameter int COLS   = 16,
  parameter int COL_W  = LCD_COL_W,
  parameter int ROW_W  = LCD_ROW_W,
  parameter int CHAR_W = LCD_CHAR_W,
  parameter logic [CHAR_W-1:0] BLANK = LCD_BLANK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [COL_W-1:0]  wr_col,
  input  logic [CHAR_W-1:0] wr_char,
  input  logic [ROW_W-1:0]  rd_row,
  input  logic [COL_W-1:0]  rd_col,
  output logic [CHAR_W-1:0] rd_char
);

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int DEPTH = 1 << IDX_W;

  logic [CHAR_W-1:0] mem [DEPTH];

  logic             wr_ok;
  logic             rd_ok;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  assign wr_ok = wr_en
    && (32'(wr_row) < ROWS)
    && (32'(wr_col) < COLS);

  assign rd_ok = (32'(rd_row) < ROWS)
    && (32'(rd_col) < COLS);

  assign wr_idx = IDX_W'(cell_idx(
    32'(wr_row), 32'(wr_col), COLS));

  assign rd_idx = IDX_W'(cell_idx(
    32'(rd_row), 32'(rd_col), COLS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= BLANK;
      end
    end else if (wr_ok) begin
      mem[wr_idx] <= wr_char;
    end
  end

  assign rd_char = rd_ok ? mem[rd_idx] : BLANK;

endmodule

// File: rtl/lcd_text_buf.sv
// Screen buffer front end: streams every cell to the LCD
// driver over a rq/ack handshake, on demand or when dirty.
module lcd_text_buf
  import lcd_pkg::*;
#(
  parameter int ROWS   = 2,
  parameter int COLS   = 16,
  parameter int COL_W  = LCD_COL_W,
  parameter int ROW_W  = LCD_ROW_W,
  parameter int CHAR_W = LCD_CHAR_W,
  parameter logic [CHAR_W-1:0] BLANK = LCD_BLANK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [COL_W-1:0]  wr_col,
  input  logic [CHAR_W-1:0] wr_char,
  input  logic              refresh,
  input  logic              auto_mode,
  input  logic              ack_lcd,
  output logic              rq_lcd,
  output logic [ROW_W-1:0]  lcd_row,
  output logic [COL_W-1:0]  lcd_column,
  output logic [CHAR_W-1:0] lcd_char,
  output logic              busy,
  output logic              done
);

  state_t            state;
  logic [ROW_W-1:0]  p_row;
  logic [COL_W-1:0]  p_col;
  logic              dirty;
  logic              pending;
  logic              wr_ok;
  logic              start;
  logic              last;
  logic              col_end;
  logic [CHAR_W-1:0] rd_char;

  lcd_char_ram #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .COL_W  (COL_W),
    .ROW_W  (ROW_W),
    .CHAR_W (CHAR_W),
    .BLANK  (BLANK)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_char (wr_char),
    .rd_row  (p_row),
    .rd_col  (p_col),
    .rd_char (rd_char)
  );

  assign wr_ok = wr_en
    && (32'(wr_row) < ROWS)
    && (32'(wr_col) < COLS);

  assign start = refresh || pending
    || (auto_mode && dirty);

  assign col_end = (32'(p_col) == COLS - 1);
  assign last    = col_end
    && (32'(p_row) == ROWS - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      p_row      <= '0;
      p_col      <= '0;
      dirty      <= 1'b0;
      pending    <= 1'b0;
      rq_lcd     <= 1'b0;
      lcd_row    <= '0;
      lcd_column <= '0;
      lcd_char   <= BLANK;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            p_row   <= '0;
            p_col   <= '0;
            pending <= 1'b0;
            dirty   <= 1'b0;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          lcd_row    <= p_row;
          lcd_column <= p_col;
          lcd_char   <= rd_char;
          rq_lcd     <= 1'b1;
          state      <= REQ;
        end
        REQ: begin
          if (ack_lcd) begin
            rq_lcd <= 1'b0;
            if (last) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              if (col_end) begin
                p_col <= '0;
                p_row <= p_row + ROW_W'(1);
              end else begin
                p_col <= p_col + COL_W'(1);
              end
              state <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // Placed after the case so a write beats the start clear.
      if (wr_ok) begin
        dirty <= 1'b1;
      end
      if (refresh && state != IDLE) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lcd_text_buf.sv
// Directed bench for lcd_text_buf with a flat expected-cell
// model; the bench plays the LCD driver side of the handshake.
module tb_lcd_text_buf;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [0:0] wr_row = '0;
  logic [5:0] wr_col = '0;
  logic [7:0] wr_char = '0;
  logic       refresh = 1'b0;
  logic       auto_mode = 1'b0;
  logic       ack_lcd = 1'b0;
  logic       rq_lcd;
  logic [0:0] lcd_row;
  logic [5:0] lcd_column;
  logic [7:0] lcd_char;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_mem [32];

  lcd_text_buf dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .wr_char    (wr_char),
    .refresh    (refresh),
    .auto_mode  (auto_mode),
    .ack_lcd    (ack_lcd),
    .rq_lcd     (rq_lcd),
    .lcd_row    (lcd_row),
    .lcd_column (lcd_column),
    .lcd_char   (lcd_char),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
        tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'h20;
  endtask

  task automatic model_wr(
    input int r, input int c, input logic [7:0] v
  );
    if (r < 2 && c < 16) exp_mem[r * 16 + c] = v;
  endtask

  task automatic host_wr(
    input int r, input int c, input logic [7:0] v
  );
    wr_en   = 1'b1;
    wr_row  = 1'(r);
    wr_col  = 6'(c);
    wr_char = v;
    @(negedge clk);
    wr_en = 1'b0;
    model_wr(r, c, v);
  endtask

  task automatic pulse_refresh();
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
  endtask

  task automatic check_quiet(input string tag, input int n);
    bit seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rq_lcd || busy) seen = 1;
    end
    check(tag, 32'(seen), 0);
  endtask

  // Serve one pass; optional hooks at given cell indices.
  task automatic serve(
    input string      nm,
    input bit         gaps,
    input int         dly_at,
    input int         spur_at,
    input int         wr_at,
    input int         w_r,
    input int         w_c,
    input logic [7:0] w_v,
    input int         ref_a,
    input int         ref_b,
    input int         abort_at
  );
    logic [0:0] h_row;
    logic [5:0] h_col;
    logic [7:0] h_chr;
    for (int k = 0; k < 32; k++) begin
      int w = 0;
      while (!rq_lcd && w < 40) begin
        @(negedge clk);
        w++;
      end
      if (!rq_lcd) begin
        check({nm, "_rq_timeout"}, 0, 1);
        return;
      end
      if (gaps && k > 0)
        check($sformatf("%s_gap%0d", nm, k), 32'(w), 1);
      check($sformatf("%s_row%0d", nm, k),
        32'(lcd_row), 32'(k / 16));
      check($sformatf("%s_col%0d", nm, k),
        32'(lcd_column), 32'(k % 16));
      check($sformatf("%s_chr%0d", nm, k),
        32'(lcd_char), 32'(exp_mem[k]));
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        check({nm, "_rst_rq"}, 32'(rq_lcd), 0);
        check({nm, "_rst_busy"}, 32'(busy), 0);
        check({nm, "_rst_done"}, 32'(done), 0);
        check({nm, "_rst_row"}, 32'(lcd_row), 0);
        check({nm, "_rst_col"}, 32'(lcd_column), 0);
        check({nm, "_rst_chr"}, 32'(lcd_char), 32'h20);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        return;
      end
      if (k == wr_at) begin
        wr_en   = 1'b1;
        wr_row  = 1'(w_r);
        wr_col  = 6'(w_c);
        wr_char = w_v;
        model_wr(w_r, w_c, w_v);
      end
      if (k == dly_at) begin
        h_row = lcd_row;
        h_col = lcd_column;
        h_chr = lcd_char;
        for (int d = 0; d < 7; d++) begin
          @(negedge clk);
          wr_en = 1'b0;
          check($sformatf("%s_hold_rq%0d", nm, d),
            32'(rq_lcd), 1);
          check($sformatf("%s_hold_cell%0d", nm, d),
            {16'(h_row), 8'(h_col), lcd_char},
            {16'(lcd_row), 8'(lcd_column), h_chr});
        end
      end
      ack_lcd = 1'b1;
      if (k == ref_a || k == ref_b) refresh = 1'b1;
      @(negedge clk);
      ack_lcd = 1'b0;
      refresh = 1'b0;
      wr_en   = 1'b0;
      check($sformatf("%s_done%0d", nm, k),
        32'(done), 32'(k == 31));
      check($sformatf("%s_rqlow%0d", nm, k),
        32'(rq_lcd), 0);
      if (k == spur_at) begin
        ack_lcd = 1'b1;
        @(negedge clk);
        ack_lcd = 1'b0;
      end
    end
    check({nm, "_busy_end"}, 32'(busy), 0);
    @(negedge clk);
    check({nm, "_done_one"}, 32'(done), 0);
  endtask

  initial begin
    clear_model();
    repeat (3) @(negedge clk);
    check("rst_rq", 32'(rq_lcd), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_row", 32'(lcd_row), 0);
    check("rst_col", 32'(lcd_column), 0);
    check("rst_chr", 32'(lcd_char), 32'h20);
    rst = 1'b0;
    @(negedge clk);

    pulse_refresh();
    serve("p_blank", 1, -1, -1, -1, 0, 0, 0, -1, -1, -1);

    host_wr(1, 0, 8'h4C);
    host_wr(1, 1, 8'h75);
    host_wr(1, 2, 8'h63);
    host_wr(1, 3, 8'h69);
    host_wr(1, 4, 8'h61);
    host_wr(1, 5, 8'h6E);
    pulse_refresh();
    serve("p_text", 1, -1, -1, -1, 0, 0, 0, -1, -1, -1);

    ack_lcd = 1'b1;
    @(negedge clk);
    ack_lcd = 1'b0;
    check_quiet("idle_ack", 3);

    pulse_refresh();
    serve("p_dly", 0, 3, 3, 3, 0, 3, 8'h58, -1, -1, -1);
    pulse_refresh();
    serve("p_clr", 0, -1, -1, -1, 0, 0, 0, -1, -1, -1);

    auto_mode = 1'b1;
    host_wr(0, 0, 8'h41);
    serve("p_auto1", 0, -1, -1, 5, 1, 15, 8'h42, -1, -1, -1);
    serve("p_auto2", 0, -1, -1, -1, 0, 0, 0, -1, -1, -1);
    check_quiet("auto_idle", 10);
    auto_mode = 1'b0;

    pulse_refresh();
    serve("p_ref1", 0, -1, -1, -1, 0, 0, 0, 2, 10, -1);
    serve("p_ref2", 0, -1, -1, -1, 0, 0, 0, -1, -1, -1);
    check_quiet("ref_no3", 10);

    pulse_refresh();
    serve("p_abort", 0, -1, -1, -1, 0, 0, 0, -1, -1, 18);
    check_quiet("abort_quiet", 10);
    pulse_refresh();
    serve("p_after", 0, -1, -1, -1, 0, 0, 0, -1, -1, -1);

    auto_mode = 1'b1;
    host_wr(0, 20, 8'h5A);
    check_quiet("oor_no_auto", 10);
    auto_mode = 1'b0;
    pulse_refresh();
    serve("p_oor", 0, -1, -1, -1, 0, 0, 0, -1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule
